// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: deframer states and IO page decode.
package uart_rx_fifo_pkg;

  // Deframer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBrk
  } rx_state_e;

  // One-hot bit of the SOC IO page that selects the RX word.
  // Read data of that word: {21'b0, overrun, frame_err, rd_valid, rd_data}.
  localparam int unsigned IO_UART_RX_bit = 3;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO with occupancy count and show-ahead read data.
module rx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [7:0]   wdata,
  input  logic         pop,
  output logic [7:0]   rdata,
  output logic         valid,
  output logic [AW:0]  count,
  output logic         drop
);
  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == Full);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign rdata = empty ? 8'h00 : mem_q[rptr_q];
  assign valid = ~empty;
  assign count = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage; contents are don't-care while empty since rdata is gated.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: input synchroniser, deframer FSM and receive FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_DIV = 48,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rxd,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLK_DIV - 1);

  logic            rx_meta_q, rx_s;
  rx_state_e       state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            baud_end, stop_push, stop_bad, fifo_drop;

  assign baud_end  = (baud_q == FullM1);
  assign stop_push = (state_q == StStop) && baud_end && rx_s;
  assign stop_bad  = (state_q == StStop) && baud_end && !rx_s;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s      <= rx_meta_q;
    end
  end

  // Deframer: half-bit start check, then samples at bit centres.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            baud_q  <= '0;
          end
        end
        StStart: begin
          if (baud_q == HalfM1) begin
            baud_q <= '0;
            bit_q  <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= StStop;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= rx_s ? StIdle : StBrk;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StBrk: begin
          // Hold off until the line returns high so a break is not re-taken as a start.
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad  | (frame_err & ~clr_err);
      overrun   <= fifo_drop | (overrun & ~clr_err);
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (stop_push),
    .wdata  (shift_q),
    .pop    (rd_en),
    .rdata  (rd_data),
    .valid  (rd_valid),
    .count  (count),
    .drop   (fifo_drop)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int unsigned CLK_DIV = 48;
  localparam int unsigned DEPTH   = 8;

  logic                   clk = 1'b0;
  logic                   resetn, rxd, rd_en, clr_err;
  logic [7:0]             rd_data;
  logic                   rd_valid, frame_err, overrun;
  logic [$clog2(DEPTH):0] count;

  logic [7:0] model_q[$];
  bit         m_ferr, m_ovr;
  int         n_checks = 0;
  int         n_errors = 0;

  uart_rx_fifo #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 8'h00;
    check_eq({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check_eq({tag, ".valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
    check_eq({tag, ".data"}, 32'(rd_data), 32'(head));
    check_eq({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
    check_eq({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  // Serial frame driven on bit-time boundaries; the line is left at the stop level.
  // With pop_at_stop, rd_en is held across the stop-sample edge, which lands
  // 3 (sync + idle detect) + CLK_DIV/2 cycles into the stop bit.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit pop_at_stop);
    rxd = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      tick(CLK_DIV);
    end
    rxd = stop_ok;
    if (pop_at_stop) begin
      tick(CLK_DIV / 2 + 2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(CLK_DIV / 2 - 3);
    end else begin
      tick(CLK_DIV);
    end
    if (pop_at_stop && model_q.size() != 0) void'(model_q.pop_front());
    if (!stop_ok) m_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(data);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    resetn = 1'b0; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    check_state("reset");
    resetn = 1'b1;
    tick(CLK_DIV);

    // Single frame, then pop back to empty.
    send_frame(8'h55, 1'b1, 1'b0);
    tick(2);
    check_state("single");
    pop_one("single_pop");
    check_state("single_empty");

    // Short low pulse must be rejected as a glitch.
    rxd = 1'b0; tick(10); rxd = 1'b1;
    tick(2 * CLK_DIV);
    check_state("glitch");

    // Nine frames into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    tick(2);
    check_state("overrun");
    for (int i = 0; i < 8; i++) pop_one("ovr_pop");
    check_state("ovr_drained");

    // Reset part-way through a frame, with a byte held and overrun set.
    send_frame(8'h11, 1'b1, 1'b0);
    b = 8'hC3;
    rxd = 1'b0; tick(CLK_DIV);
    for (int i = 0; i < 4; i++) begin rxd = b[i]; tick(CLK_DIV); end
    resetn = 1'b0; rxd = 1'b1;
    tick(2);
    model_q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
    check_state("in_reset");
    resetn = 1'b1;
    tick(2 * CLK_DIV);
    check_state("after_reset");
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(2);
    check_state("rearm");
    pop_one("rearm_pop");

    // Full FIFO with a pop on the stop-sample edge of a ninth frame.
    for (int i = 0; i < 8; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(2);
    check_state("full_pop");
    for (int i = 0; i < 7; i++) pop_one("full_drain");
    check_eq("last_is_a5", 32'(rd_data), 32'h0000_00A5);
    pop_one("full_last");
    check_state("full_empty");

    // Framing error followed by a held-low break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(20 * CLK_DIV);
    check_state("break");
    rxd = 1'b1;
    tick(CLK_DIV);
    send_frame(8'h42, 1'b1, 1'b0);
    tick(2);
    check_state("after_break");
    clear_errors();
    check_state("clr_err");
    pop_one("brk_pop");

    // Random traffic: mostly good frames, occasional bad stop, random pops and clears.
    for (int it = 0; it < 24; it++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, 1'b0);
      rxd = 1'b1;
      tick($urandom_range(0, 20));
      tick(2);
      check_state("rand_frame");
      for (int p = $urandom_range(0, 3); p > 0; p--) pop_one("rand_pop");
      if ($urandom_range(0, 3) == 0) clear_errors();
    end
    check_state("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
